// File: rtl/neuron_mac_accumulator.sv
// Serial multiply-accumulate for one MLP neuron.
// Operand pairs arrive over a valid/ready stream and their full-precision
// signed products are summed into a wide accumulator. After the last term,
// the bias is added, the sum is rescaled back to the operand Q format and
// then saturated. The single result is held on an output handshake.
module neuron_mac_accumulator #(
    parameter int bits       = 16,
    parameter int FRAC       = 8,
    parameter int NUM_INPUTS = 784
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic signed [bits-1:0] bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [bits-1:0] x_in,
    input  logic signed [bits-1:0] w_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [bits-1:0] result,
    output logic                   overflow,
    output logic                   busy
);

    // Wide enough for NUM_INPUTS worst-case products plus the shifted bias.
    localparam int ACC_W = 2*bits + $clog2(NUM_INPUTS) + 1;
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

    // Representable range of the result, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] RMAX =
        $signed({{(ACC_W-bits+1){1'b0}}, {(bits-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] RMIN = -RMAX - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  count;
    logic signed [bits-1:0]   bias_q;

    logic signed [2*bits-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  scaled;

    // Clamp a rescaled sum into the result width; MSB of the return is the clamp flag.
    function automatic logic [bits:0] saturate(input logic signed [ACC_W-1:0] r);
        logic [bits:0] o;
        if (r > RMAX)
            o = {1'b1, 1'b0, {(bits-1){1'b1}}};
        else if (r < RMIN)
            o = {1'b1, 1'b1, {(bits-1){1'b0}}};
        else
            o = {1'b0, r[bits-1:0]};
        return o;
    endfunction

    // Full-precision product, sign-extended bias and the floor-rescaled sum.
    always_comb begin
        prod     = x_in * w_in;
        prod_ext = {{(ACC_W-2*bits){prod[2*bits-1]}}, prod};
        bias_ext = {{(ACC_W-bits){bias_q[bits-1]}}, bias_q};
        sum_s    = acc + (bias_ext <<< FRAC);
        scaled   = sum_s >>> FRAC;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode; handshake and status outputs depend on state alone.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:  if (start) state_d = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && count == LAST) state_d = BIAS;
            end
            BIAS:  state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator, term counter, latched bias and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            bias_q   <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc    <= '0;
                    count  <= '0;
                    bias_q <= bias;
                end
                ACCUM: if (in_valid) begin
                    acc   <= acc + prod_ext;
                    count <= count + CNT_W'(1);
                end
                BIAS: {overflow, result} <= saturate(scaled);
                default: ;
            endcase
        end
    end

endmodule
